// File: rtl/div_share_arb.sv
// div_share_arb: lets the n0prime engine (port 0) and the R^2 mod n engine
// (port 1) share one nonrestoring divider.
//
// Round-robin arbitration between the two ports. The winner's operands are
// latched and the divider gets a one-cycle start pulse. The divider's results
// are captured and returned to the owning port with a one-cycle ack. A zero
// divisor skips the divider entirely. A watchdog aborts a divide that never
// completes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   req0, a0, b0        port 0 request level, dividend, divisor
//   req1, a1, b1        port 1 request level, dividend, divisor
//   ack0, ack1          one-cycle completion pulse to the owning port
//   q_res, r_res, err   quotient, remainder, error flag; valid with ack, held after
//   busy                high whenever the arbiter is not idle
//   div_start           one-cycle start pulse to the divider
//   div_q, div_m        latched dividend / divisor driven to the divider
//   div_done            divider completion
//   div_qout, div_rem   divider quotient / remainder
module div_share_arb #(
  parameter int unsigned WIDTH   = 1025,
  parameter int unsigned TIMEOUT = 2200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] q_res,
  output logic [WIDTH-1:0] r_res,
  output logic             err,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_qout,
  input  logic [WIDTH-1:0] div_rem
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] WdLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] WdMax  = CntW'(TIMEOUT);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StGrant = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StWait  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CntW-1:0]  wd_cnt_q, wd_cnt_d;
  logic [CntW-1:0]  wd_inc;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] q_res_q, q_res_d;
  logic [WIDTH-1:0] r_res_q, r_res_d;
  logic             err_q, err_d;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    wd_cnt_d = wd_cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    q_res_d  = q_res_q;
    r_res_d  = r_res_q;
    err_d    = err_q;
    // Saturating so a stuck count can never wrap back below the limit.
    wd_inc   = (wd_cnt_q == WdMax) ? wd_cnt_q : wd_cnt_q + CntW'(1);

    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time gets the grant.
          owner_d = (req0 && req1) ? ~last_q : req1;
          last_d  = owner_d;
          opa_d   = owner_d ? a1 : a0;
          opb_d   = owner_d ? b1 : b0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (opb_q == '0) begin
          q_res_d = '1;
          r_res_d = opa_q;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StStart;
        end
      end
      StStart: begin
        wd_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        wd_cnt_d = wd_inc;
        // Completion takes priority over a coincident timeout. The limit is
        // checked on the incremented value so the abort ack lands exactly
        // TIMEOUT cycles after div_start.
        if (div_done) begin
          q_res_d = div_qout;
          r_res_d = div_rem;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (wd_inc >= WdLast) begin
          q_res_d = '0;
          r_res_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      q_res_q  <= '0;
      r_res_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      q_res_q  <= q_res_d;
      r_res_q  <= r_res_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign div_start = (state_q == StStart);
  assign ack0      = (state_q == StDone) && !owner_q;
  assign ack1      = (state_q == StDone) && owner_q;
  assign div_q     = opa_q;
  assign div_m     = opb_q;
  assign q_res     = q_res_q;
  assign r_res     = r_res_q;
  assign err       = err_q;

endmodule

// File: tb/tb_div_share_arb.sv
// Bench for div_share_arb: directed requests, a behavioural divider model,
// and a scoreboard queue of hand-computed expected acks.
module tb_div_share_arb;

  localparam int unsigned W   = 64;
  localparam int unsigned TO  = 20;
  localparam int          LAT = 5;

  typedef struct {
    logic         port;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1, err, busy, div_start, div_done;
  logic [W-1:0] q_res, r_res, div_q, div_m, div_qout, div_rem;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc = 0;
  int   starts = 0;
  int   acks = 0;
  int   start_cyc = 0;
  int   ack_cyc = 0;
  bit   hang = 1'b0;

  div_share_arb #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .q_res(q_res), .r_res(r_res), .err(err), .busy(busy),
    .div_start(div_start), .div_q(div_q), .div_m(div_m),
    .div_done(div_done), .div_qout(div_qout), .div_rem(div_rem)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: fixed latency after div_start, can be told to hang.
  // It ignores rst so that a result can arrive after an aborted operation.
  int           m_cnt = 0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_m = '1;
  always @(posedge clk) begin
    if (div_start) begin
      m_cnt <= LAT;
      m_q   <= div_q;
      m_m   <= div_m;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign div_done = (m_cnt == 1) && !hang;
  assign div_qout = (m_m != '0) ? m_q / m_m : '0;
  assign div_rem  = (m_m != '0) ? m_q % m_m : '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [W-1:0] q, input logic [W-1:0] r,
                      input logic e);
    exp_t x;
    x.port = port;
    x.q    = q;
    x.r    = r;
    x.err  = e;
    sb.push_back(x);
  endtask

  // Monitor: counts div_start pulses and checks every ack against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (div_start) begin
          starts++;
          start_cyc = cyc;
        end
        if (ack0 || ack1) begin
          acks++;
          check("ack_exclusive", W'(ack0 && ack1), '0);
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", ack0, ack1);
          end else begin
            e = sb.pop_front();
            check("ack_port", W'(ack1), W'(e.port));
            check("q_res", q_res, e.q);
            check("r_res", r_res, e.r);
            check("err", W'(err), W'(e.err));
          end
        end
      end
    end
  end

  // Wait for n acks within budget cycles; optionally drop req on its ack.
  task automatic serve(input int n, input int budget, input bit drop);
    int seen = 0;
    int t = 0;
    while (seen < n && t < budget) begin
      @(negedge clk);
      t++;
      if (ack0 || ack1) begin
        seen++;
        ack_cyc = cyc;
        if (drop) begin
          if (ack0) req0 = 1'b0;
          if (ack1) req1 = 1'b0;
        end
      end
    end
    check("ack_count_in_budget", W'(seen), W'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int s0;
    int a_before;
    int t;
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ack0", W'(ack0), '0);
    check("rst_ack1", W'(ack1), '0);
    check("rst_busy", W'(busy), '0);
    check("rst_div_start", W'(div_start), '0);
    check("rst_err", W'(err), '0);
    check("rst_q_res", q_res, '0);
    check("rst_r_res", r_res, '0);
    check("rst_div_q", div_q, '0);
    check("rst_div_m", div_m, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single port-0 divide: 2^32 / 197
    a0 = 64'h1_0000_0000;
    b0 = 64'hC5;
    push(1'b0, 64'd21801864, 64'd88, 1'b0);
    req0 = 1'b1;
    serve(1, 50, 1'b1);
    @(negedge clk);
    check("ack0_one_cycle", W'(ack0), '0);
    check("q_res_held", q_res, 64'd21801864);

    // Simultaneous requests right after reset: port 0 then port 1
    do_reset();
    a0 = 64'd100;  b0 = 64'd9;
    a1 = 64'd1000; b1 = 64'd7;
    s0 = starts;
    push(1'b0, 64'd11, 64'd1, 1'b0);
    push(1'b1, 64'd142, 64'd6, 1'b0);
    req0 = 1'b1;
    req1 = 1'b1;
    serve(2, 100, 1'b1);
    check("two_starts", W'(starts - s0), 64'd2);

    // Both held high for six operations: strict alternation
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 64'd11, 64'd1, 1'b0);
      push(1'b1, 64'd142, 64'd6, 1'b0);
    end
    req0 = 1'b1;
    req1 = 1'b1;
    serve(6, 200, 1'b0);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

    // Divide by zero on port 1: no divider start
    a1 = 64'h1234;
    b1 = '0;
    s0 = starts;
    push(1'b1, '1, 64'h1234, 1'b1);
    req1 = 1'b1;
    serve(1, 50, 1'b1);
    check("dbz_no_start", W'(starts - s0), '0);

    // Hung divider: abort ack exactly TO cycles after div_start
    hang = 1'b1;
    a0 = 64'd77;
    b0 = 64'd5;
    push(1'b0, '0, '0, 1'b1);
    req0 = 1'b1;
    serve(1, TO + 50, 1'b1);
    check("timeout_latency", W'(ack_cyc - start_cyc), W'(TO));
    hang = 1'b0;
    a1 = 64'd1000;
    b1 = 64'd7;
    push(1'b1, 64'd142, 64'd6, 1'b0);
    req1 = 1'b1;
    serve(1, 50, 1'b1);

    // Reset during WAIT: no ack, late div_done ignored, then normal service
    a0 = 64'd500;
    b0 = 64'd3;
    s0 = starts;
    req0 = 1'b1;
    t = 0;
    while (starts == s0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_test_started", W'(starts - s0), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", W'(busy), '0);
    check("midrst_acks", W'({ack0, ack1}), '0);
    check("midrst_div_q", div_q, '0);
    check("midrst_div_m", div_m, '0);
    check("midrst_q_res", q_res, '0);
    check("midrst_err", W'(err), '0);
    req0 = 1'b0;
    rst  = 1'b0;
    a_before = acks;
    repeat (10) @(negedge clk);
    check("midrst_no_ack", W'(acks), W'(a_before));
    check("midrst_idle", W'(busy), '0);
    push(1'b0, 64'd166, 64'd2, 1'b0);
    req0 = 1'b1;
    serve(1, 50, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
